// File: rtl/memory_bus_interface_pkg.sv
// Shared definitions for the memory bus responder: phase codes driven on the
// bus_phase pins, FSM state encoding and pin-bus output-enable patterns.
package memory_bus_interface_pkg;

    // Phase codes seen by the external address latch / memory
    localparam logic [1:0] PHASE_IDLE   = 2'b00;
    localparam logic [1:0] PHASE_ADR_LO = 2'b01;
    localparam logic [1:0] PHASE_ADR_HI = 2'b10;
    localparam logic [1:0] PHASE_DATA   = 2'b11;

    // Pin-bus output enable patterns (the bus is always driven as a whole byte)
    localparam logic [7:0] OE_DRIVE   = 8'hFF;
    localparam logic [7:0] OE_RELEASE = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_LO = 3'd1,
        S_ADDR_HI = 3'd2,
        S_DATA    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/memory_bus_interface.sv
// Responder for the core's memory requests. Each request is executed on the
// shared 8-bit uio pin bus as: address low byte, address high byte (skippable
// when the external latch already holds it), then one or more data cycles.
//
// Handshake: req is a single-cycle strobe that is only looked at while idle
// (busy = 0); address/rw/wdata are captured on that cycle. Completion is a
// single-cycle ready pulse; rdata is valid from that pulse until the next read
// completes. A req seen while busy is dropped, never queued.
module memory_bus_interface
    import memory_bus_interface_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter bit          SKIP_HI     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] address,
    input  logic        rw,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        busy,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe,
    output logic [1:0]  bus_phase,
    output logic        write_strobe
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      next_state;
    logic [15:0] addr_q;
    logic        rw_q;
    logic [7:0]  wdata_q;
    logic [7:0]  last_hi;
    logic        hi_valid;
    logic [3:0]  wait_cnt;
    logic        hi_matches;
    logic        last_data_cycle;

    // High byte may be skipped only if the latch provably holds this value
    assign hi_matches      = SKIP_HI && hi_valid && (addr_q[15:8] == last_hi);
    assign last_data_cycle = (state == S_DATA) && (wait_cnt == 4'd0);

    // State register; reset aborts any transaction and releases the pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and pin/phase outputs, all decoded from the current state
    always_comb begin
        next_state   = state;
        uio_out      = 8'h00;
        uio_oe       = OE_RELEASE;
        bus_phase    = PHASE_IDLE;
        write_strobe = 1'b0;
        ready        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req) next_state = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                uio_out    = addr_q[7:0];
                uio_oe     = OE_DRIVE;
                bus_phase  = PHASE_ADR_LO;
                next_state = hi_matches ? S_DATA : S_ADDR_HI;
            end
            S_ADDR_HI: begin
                uio_out    = addr_q[15:8];
                uio_oe     = OE_DRIVE;
                bus_phase  = PHASE_ADR_HI;
                next_state = S_DATA;
            end
            S_DATA: begin
                bus_phase = PHASE_DATA;
                if (!rw_q) begin
                    uio_out      = wdata_q;
                    uio_oe       = OE_DRIVE;
                    write_strobe = 1'b1;
                end
                if (wait_cnt == 4'd0) next_state = S_DONE;
            end
            S_DONE: begin
                ready      = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Request capture, high-byte latch tracking, wait counter and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= 16'h0000;
            rw_q     <= 1'b0;
            wdata_q  <= 8'h00;
            last_hi  <= 8'h00;
            hi_valid <= 1'b0;
            wait_cnt <= 4'd0;
            rdata    <= 8'h00;
        end else begin
            if (state == S_IDLE && req) begin
                addr_q  <= address;
                rw_q    <= rw;
                wdata_q <= wdata;
            end
            if (state == S_ADDR_HI) begin
                last_hi  <= addr_q[15:8];
                hi_valid <= 1'b1;
            end
            if (state != S_DATA && next_state == S_DATA) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == S_DATA && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (last_data_cycle && rw_q) begin
                rdata <= uio_in;
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_interface.sv
// Directed bench for memory_bus_interface. Three instances share clock, reset
// and request fields: dut_a (defaults), dut_b (no high-byte skip) and dut_c
// (three wait states). Each is exercised in turn through its own req line.
module tb_memory_bus_interface;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] address = 16'h0000;
    logic        rw = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  uio_in = 8'h00;
    logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;

    logic [7:0] a_rdata, a_uio_out, a_uio_oe;
    logic       a_ready, a_busy, a_ws;
    logic [1:0] a_phase;
    logic [7:0] b_rdata, b_uio_out, b_uio_oe;
    logic       b_ready, b_busy, b_ws;
    logic [1:0] b_phase;
    logic [7:0] c_rdata, c_uio_out, c_uio_oe;
    logic       c_ready, c_busy, c_ws;
    logic [1:0] c_phase;

    int tests_run = 0;
    int tests_failed = 0;

    memory_bus_interface #(.WAIT_CYCLES(0), .SKIP_HI(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .address(address), .rw(rw),
        .wdata(wdata), .rdata(a_rdata), .ready(a_ready), .busy(a_busy),
        .uio_in(uio_in), .uio_out(a_uio_out), .uio_oe(a_uio_oe),
        .bus_phase(a_phase), .write_strobe(a_ws)
    );

    memory_bus_interface #(.WAIT_CYCLES(0), .SKIP_HI(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .address(address), .rw(rw),
        .wdata(wdata), .rdata(b_rdata), .ready(b_ready), .busy(b_busy),
        .uio_in(uio_in), .uio_out(b_uio_out), .uio_oe(b_uio_oe),
        .bus_phase(b_phase), .write_strobe(b_ws)
    );

    memory_bus_interface #(.WAIT_CYCLES(3), .SKIP_HI(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .address(address), .rw(rw),
        .wdata(wdata), .rdata(c_rdata), .ready(c_ready), .busy(c_busy),
        .uio_in(uio_in), .uio_out(c_uio_out), .uio_oe(c_uio_oe),
        .bus_phase(c_phase), .write_strobe(c_ws)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_rdata", a_rdata, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_uio_out", a_uio_out, 0);
        check("rst_a_uio_oe", a_uio_oe, 0);
        check("rst_a_phase", a_phase, 0);
        check("rst_a_ws", a_ws, 0);
        check("rst_b_busy", b_busy, 0);
        check("rst_c_busy", c_busy, 0);
        rst_n = 1'b1;
        step();

        // ---------------- A: first read 12A5 ----------------
        address = 16'h12A5; rw = 1'b1; req_a = 1'b1;
        step(); req_a = 1'b0;
        check("r1_lo_phase", a_phase, 2'b01);
        check("r1_lo_out", a_uio_out, 8'hA5);
        check("r1_lo_oe", a_uio_oe, 8'hFF);
        check("r1_lo_busy", a_busy, 1);
        step();
        check("r1_hi_phase", a_phase, 2'b10);
        check("r1_hi_out", a_uio_out, 8'h12);
        step();
        check("r1_data_phase", a_phase, 2'b11);
        check("r1_data_oe", a_uio_oe, 8'h00);
        check("r1_data_ready", a_ready, 0);
        uio_in = 8'h3C;
        step();
        check("r1_ready", a_ready, 1);
        check("r1_rdata", a_rdata, 8'h3C);
        check("r1_done_phase", a_phase, 2'b00);
        check("r1_done_oe", a_uio_oe, 8'h00);
        uio_in = 8'h00;
        step();
        check("r1_ready_pulse", a_ready, 0);
        check("r1_idle_busy", a_busy, 0);

        // ---------------- A: read 1277, high byte skipped ----------------
        address = 16'h1277; req_a = 1'b1;
        step(); req_a = 1'b0;
        check("r2_lo_out", a_uio_out, 8'h77);
        step();
        check("r2_skip_phase", a_phase, 2'b11);
        uio_in = 8'h5A;
        step();
        check("r2_ready", a_ready, 1);
        check("r2_rdata", a_rdata, 8'h5A);
        step();

        // ---------------- A: write 0040 <= 9E ----------------
        address = 16'h0040; wdata = 8'h9E; rw = 1'b0; req_a = 1'b1;
        step(); req_a = 1'b0;
        check("w_lo_out", a_uio_out, 8'h40);
        step();
        check("w_hi_phase", a_phase, 2'b10);
        check("w_hi_out", a_uio_out, 8'h00);
        step();
        check("w_data_phase", a_phase, 2'b11);
        check("w_data_out", a_uio_out, 8'h9E);
        check("w_data_oe", a_uio_oe, 8'hFF);
        check("w_data_ws", a_ws, 1);
        uio_in = 8'hEE;
        step();
        check("w_ready", a_ready, 1);
        check("w_rdata_kept", a_rdata, 8'h5A);
        check("w_done_ws", a_ws, 0);
        step();

        // ---------------- A: req while busy, then back-to-back ----------------
        address = 16'h3456; rw = 1'b1; req_a = 1'b1;
        step(); req_a = 1'b0;
        check("bb_lo_out", a_uio_out, 8'h56);
        step();
        check("bb_hi_out", a_uio_out, 8'h34);
        address = 16'hABCD; rw = 1'b0; wdata = 8'hFF; req_a = 1'b1;
        step(); req_a = 1'b0;
        check("bb_data_phase", a_phase, 2'b11);
        check("bb_data_oe_read", a_uio_oe, 8'h00);
        check("bb_data_ws", a_ws, 0);
        uio_in = 8'h77;
        step();
        check("bb_ready", a_ready, 1);
        check("bb_rdata", a_rdata, 8'h77);
        address = 16'h3411; rw = 1'b1;
        step();
        check("bb_no_queue_busy", a_busy, 0);
        check("bb_no_queue_ready", a_ready, 0);
        req_a = 1'b1;
        step(); req_a = 1'b0;
        check("bb2_lo_phase", a_phase, 2'b01);
        check("bb2_lo_out", a_uio_out, 8'h11);
        step();
        check("bb2_skip_phase", a_phase, 2'b11);
        uio_in = 8'h0F;
        step();
        check("bb2_ready", a_ready, 1);
        check("bb2_rdata", a_rdata, 8'h0F);
        step();

        // ---------------- B: SKIP_HI = 0 keeps the high phase ----------------
        address = 16'h12A5; rw = 1'b1; req_b = 1'b1;
        step(); req_b = 1'b0;
        step();
        step();
        uio_in = 8'h44;
        step();
        check("b_r1_ready", b_ready, 1);
        check("b_r1_rdata", b_rdata, 8'h44);
        step();
        address = 16'h1277; req_b = 1'b1;
        step(); req_b = 1'b0;
        check("b_r2_lo_out", b_uio_out, 8'h77);
        step();
        check("b_r2_hi_phase", b_phase, 2'b10);
        check("b_r2_hi_out", b_uio_out, 8'h12);
        step();
        check("b_r2_data_phase", b_phase, 2'b11);
        uio_in = 8'h45;
        step();
        check("b_r2_ready", b_ready, 1);
        check("b_r2_rdata", b_rdata, 8'h45);
        step();

        // ---------------- C: WAIT_CYCLES = 3 read ----------------
        address = 16'h0102; rw = 1'b1; req_c = 1'b1;
        step(); req_c = 1'b0;
        check("c_lo_out", c_uio_out, 8'h02);
        step();
        check("c_hi_out", c_uio_out, 8'h01);
        step();
        uio_in = 8'h11;
        check("c_d0_phase", c_phase, 2'b11);
        step();
        check("c_d1_phase", c_phase, 2'b11);
        check("c_d1_ready", c_ready, 0);
        step();
        check("c_d2_phase", c_phase, 2'b11);
        step();
        check("c_d3_phase", c_phase, 2'b11);
        check("c_d3_ready", c_ready, 0);
        uio_in = 8'h22;
        step();
        check("c_ready_lat7", c_ready, 1);
        check("c_rdata", c_rdata, 8'h22);
        step();
        check("c_ready_pulse", c_ready, 0);

        // ---------------- A: reset during write data phase ----------------
        address = 16'h5566; wdata = 8'hC3; rw = 1'b0; req_a = 1'b1;
        step(); req_a = 1'b0;
        step();
        step();
        check("rw_data_ws", a_ws, 1);
        check("rw_data_oe", a_uio_oe, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("rw_async_oe", a_uio_oe, 8'h00);
        check("rw_async_ws", a_ws, 0);
        check("rw_async_busy", a_busy, 0);
        check("rw_async_phase", a_phase, 2'b00);
        check("rw_async_ready", a_ready, 0);
        check("rw_async_rdata", a_rdata, 8'h00);
        step();
        rst_n = 1'b1;
        step();
        check("rw_no_ready", a_ready, 0);
        address = 16'h5500; rw = 1'b1; req_a = 1'b1;
        step(); req_a = 1'b0;
        check("rw_next_lo_out", a_uio_out, 8'h00);
        step();
        check("rw_next_hi_phase", a_phase, 2'b10);
        check("rw_next_hi_out", a_uio_out, 8'h55);
        step();
        uio_in = 8'h99;
        step();
        check("rw_next_ready", a_ready, 1);
        check("rw_next_rdata", a_rdata, 8'h99);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
